rr_demux_sched: RTL

- Round-robin scheduler and sequencer for a 1-to-4 demultiplexed data path.
- Accepts a single valid/ready input stream and steers bursts of BURST words to each of four output channels in turn, skipping disabled channels.
- Inserts one guard cycle on every channel switch and holds one registered output word.
- Sits between a shared producer and four consumers; it replaces static select-driven demux control.

---
 rtl/rr_demux_sched.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rr_demux_sched.sv
// Round-robin scheduler for a 1-to-4 demux: sends BURST words per enabled channel,
// with one guard cycle on each switch and a single registered output word.
module rr_demux_sched #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    ch_en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    sel,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, SEND, SWITCH} state_t;

  localparam logic [7:0] BURST_L = 8'(BURST);

  state_t        state_reg;
  logic [1:0]    sel_reg;
  logic [1:0]    bsel_reg;
  logic [7:0]    cnt_reg;
  logic          incl_reg;
  logic          buf_valid_reg;
  logic [DW-1:0] data_reg;
  logic          in_xfer;
  logic          out_xfer;

  // First enabled channel after base (incl=0) or at/after base (incl=1).
  // Scanning from the farthest offset down lets the nearest hit win.
  function automatic logic [1:0] pick(input logic [3:0] en, input logic [1:0] base,
                                      input logic incl);
    logic [1:0] res;
    logic [2:0] off;
    logic [1:0] idx;
    res = base;
    for (int k = 3; k >= 0; k--) begin
      off = incl ? 3'(k) : 3'(k + 1);
      idx = base + off[1:0];
      if (en[idx]) res = idx;
    end
    return res;
  endfunction

  assign in_ready = (state_reg == SEND) && ch_en[sel_reg] &&
                    (!buf_valid_reg || out_ready[bsel_reg]);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = buf_valid_reg && out_ready[bsel_reg];
  assign out_data = data_reg;
  assign sel      = sel_reg;
  assign busy     = (state_reg != IDLE);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_out_valid
      assign out_valid[gi] = buf_valid_reg && (bsel_reg == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sel_reg   <= 2'd0;
      cnt_reg   <= 8'd0;
      incl_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= 8'd0;
          if (ch_en != 4'b0000) begin
            state_reg <= SWITCH;
            incl_reg  <= 1'b1;
          end
        end
        SEND: begin
          if (ch_en == 4'b0000) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
          end else if (!ch_en[sel_reg]) begin
            state_reg <= SWITCH;
            incl_reg  <= 1'b0;
            cnt_reg   <= 8'd0;
          end else if (in_xfer) begin
            if (cnt_reg + 8'd1 == BURST_L) begin
              state_reg <= SWITCH;
              incl_reg  <= 1'b0;
              cnt_reg   <= 8'd0;
            end else begin
              cnt_reg <= cnt_reg + 8'd1;
            end
          end
        end
        SWITCH: begin
          sel_reg   <= pick(ch_en, sel_reg, incl_reg);
          incl_reg  <= 1'b0;
          state_reg <= (ch_en == 4'b0000) ? IDLE : SEND;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A new word wins over a simultaneous drain; the word keeps its own channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_reg <= 1'b0;
      bsel_reg      <= 2'd0;
      data_reg      <= '0;
    end else if (in_xfer) begin
      buf_valid_reg <= 1'b1;
      bsel_reg      <= sel_reg;
      data_reg      <= in_data;
    end else if (out_xfer) begin
      buf_valid_reg <= 1'b0;
    end
  end

endmodule
